// File: rtl/nbit_mx1_skid_mux_pkg.sv
// Shared constants for operand/forwarding source selection and the selector width helper.
package nbit_mx1_skid_mux_pkg;

    localparam int FWD_SRC_REG   = 0;
    localparam int FWD_SRC_EXMEM = 1;
    localparam int FWD_SRC_MEMWB = 2;
    localparam int FWD_SRC_IMM   = 3;

    // NOP-safe zero used to scrub data registers on reset and flush.
    localparam logic [31:0] DEFAULT_FLUSH_VAL = 32'h0000_0000;

    function automatic int sel_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nbit_mx1_skid_mux_mux.sv
// Pure combinational M:1 selector; an index with no matching source yields FLUSH_VAL.
module nbit_mx1_mux
    import nbit_mx1_skid_mux_pkg::*;
#(
    parameter int          N         = 32,
    parameter int          M         = 4,
    parameter logic [N-1:0] FLUSH_VAL = N'(DEFAULT_FLUSH_VAL),
    localparam int         SEL_W     = sel_width(M)
) (
    input  logic [M*N-1:0]   mux_inputs,
    input  logic [SEL_W-1:0] selection,
    output logic [N-1:0]     mux_out,
    output logic             sel_oob
);

    logic [N-1:0] src [M];

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_unpack
            assign src[gi] = mux_inputs[gi*N +: N];
        end
    endgenerate

    // Equality scan instead of direct indexing keeps non-power-of-two M safe.
    always_comb begin
        mux_out = FLUSH_VAL;
        sel_oob = 1'b1;
        for (int k = 0; k < M; k++) begin
            if (selection == SEL_W'(k)) begin
                mux_out = src[k];
                sel_oob = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nbit_mx1_skid_mux.sv
// M:1 selector feeding a valid/ready register stage with a one-entry skid buffer.
module nbit_mx1_skid_mux
    import nbit_mx1_skid_mux_pkg::*;
#(
    parameter int           N         = 32,
    parameter int           M         = 4,
    parameter logic [N-1:0] FLUSH_VAL = N'(DEFAULT_FLUSH_VAL),
    localparam int          SEL_W     = sel_width(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M*N-1:0]   mux_inputs,
    input  logic [SEL_W-1:0] selection,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [N-1:0]     mux_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_err
);

    logic [N-1:0] sel_word;
    logic         sel_oob;

    logic [N-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] skid_q, skid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q, in_ready_d;
    logic         sel_err_q, sel_err_d;

    logic accept;
    logic out_load_en;

    nbit_mx1_mux #(
        .N         (N),
        .M         (M),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_mux (
        .mux_inputs (mux_inputs),
        .selection  (selection),
        .mux_out    (sel_word),
        .sel_oob    (sel_oob)
    );

    assign accept      = in_valid & in_ready_q & ~flush;
    assign out_load_en = ~out_valid_q | out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = sel_err_q | (accept & sel_oob);

        if (flush) begin
            out_d        = FLUSH_VAL;
            out_valid_d  = 1'b0;
            skid_d       = FLUSH_VAL;
            skid_valid_d = 1'b0;
        end else if (out_load_en) begin
            // in_ready is low whenever the skid is full, so the skid drain
            // and a new accept can never collide here.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = sel_word;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = sel_word;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= FLUSH_VAL;
            out_valid_q  <= 1'b0;
            skid_q       <= FLUSH_VAL;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            sel_err_q    <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign mux_out   = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_nbit_mx1_skid_mux.sv
// Directed bench: a 4-source stage for streaming/backpressure/flush and a 3-source stage for bad selects.
module tb_nbit_mx1_skid_mux;

    logic        clk;
    logic        rst;

    logic [31:0] mux_inputs_a;
    logic [1:0]  selection_a;
    logic        in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, sel_err_a;
    logic [7:0]  mux_out_a;

    logic [23:0] mux_inputs_b;
    logic [1:0]  selection_b;
    logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, sel_err_b;
    logic [7:0]  mux_out_b;

    int n_checks = 0;
    int n_errors = 0;

    nbit_mx1_skid_mux #(.N(8), .M(4), .FLUSH_VAL(8'h00)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .mux_inputs (mux_inputs_a),
        .selection  (selection_a),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .flush      (flush_a),
        .mux_out    (mux_out_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a),
        .sel_err    (sel_err_a)
    );

    nbit_mx1_skid_mux #(.N(8), .M(3), .FLUSH_VAL(8'h00)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .mux_inputs (mux_inputs_b),
        .selection  (selection_b),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .flush      (flush_b),
        .mux_out    (mux_out_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .sel_err    (sel_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        selection_a  = 2'd0;
        in_valid_a   = 1'b0;
        flush_a      = 1'b0;
        out_ready_a  = 1'b0;
        mux_inputs_b = {8'h2C, 8'h2B, 8'h2A};
        selection_b  = 2'd0;
        in_valid_b   = 1'b0;
        flush_b      = 1'b0;
        out_ready_b  = 1'b0;

        // Reset state, observed while reset is still asserted
        #12;
        chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready_a},  32'd1);
        chk("rst_mux_out",   {24'd0, mux_out_a},   32'h00);
        chk("rst_sel_err",   {31'd0, sel_err_a},   32'd0);
        rst = 1'b1;
        step();
        chk("idle_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("idle_in_ready",  {31'd0, in_ready_a},  32'd1);

        // Streaming, one transfer per cycle
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            selection_a = 2'(i);
            step();
            chk($sformatf("stream_data%0d", i), {24'd0, mux_out_a}, 32'hA0 + 32'(i) * 32'h11);
            chk($sformatf("stream_valid%0d", i), {31'd0, out_valid_a}, 32'd1);
            chk($sformatf("stream_rdy%0d", i), {31'd0, in_ready_a}, 32'd1);
        end
        in_valid_a = 1'b0;
        step();
        chk("stream_drained", {31'd0, out_valid_a}, 32'd0);

        // Backpressure into the skid
        out_ready_a  = 1'b0;
        in_valid_a   = 1'b1;
        selection_a  = 2'd0;
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h11};
        step();
        chk("bp_first_data",  {24'd0, mux_out_a},  32'h11);
        chk("bp_first_rdy",   {31'd0, in_ready_a}, 32'd1);
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h22};
        step();
        chk("bp_hold_data",   {24'd0, mux_out_a},   32'h11);
        chk("bp_skid_rdy",    {31'd0, in_ready_a},  32'd0);
        chk("bp_skid_valid",  {31'd0, out_valid_a}, 32'd1);
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h44};
        step();
        chk("bp_ignored_data", {24'd0, mux_out_a},  32'h11);
        chk("bp_ignored_rdy",  {31'd0, in_ready_a}, 32'd0);
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        step();
        chk("bp_drain_data",  {24'd0, mux_out_a},   32'h22);
        chk("bp_drain_valid", {31'd0, out_valid_a}, 32'd1);
        chk("bp_drain_rdy",   {31'd0, in_ready_a},  32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid_a}, 32'd0);

        // Flush beats a pending accept and a full skid
        out_ready_a  = 1'b0;
        in_valid_a   = 1'b1;
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h55};
        step();
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h66};
        step();
        chk("fl_full_rdy", {31'd0, in_ready_a}, 32'd0);
        flush_a      = 1'b1;
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h33};
        step();
        chk("fl_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("fl_in_ready",  {31'd0, in_ready_a},  32'd1);
        chk("fl_mux_out",   {24'd0, mux_out_a},   32'h00);
        flush_a     = 1'b0;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        step();
        chk("fl_dropped_valid", {31'd0, out_valid_a}, 32'd0);
        chk("fl_dropped_data",  {24'd0, mux_out_a},   32'h00);

        // Bad select offered during a flush must not set sel_err
        flush_b     = 1'b1;
        in_valid_b  = 1'b1;
        out_ready_b = 1'b1;
        selection_b = 2'd3;
        step();
        chk("oob_flush_err",   {31'd0, sel_err_b},   32'd0);
        chk("oob_flush_valid", {31'd0, out_valid_b}, 32'd0);
        flush_b = 1'b0;
        step();
        chk("oob_data",  {24'd0, mux_out_b},   32'h00);
        chk("oob_valid", {31'd0, out_valid_b}, 32'd1);
        chk("oob_err",   {31'd0, sel_err_b},   32'd1);
        selection_b = 2'd1;
        step();
        chk("oob_after1_data", {24'd0, mux_out_b}, 32'h2B);
        chk("oob_after1_err",  {31'd0, sel_err_b}, 32'd1);
        selection_b = 2'd2;
        step();
        chk("oob_after2_data", {24'd0, mux_out_b}, 32'h2C);
        chk("oob_after2_err",  {31'd0, sel_err_b}, 32'd1);
        in_valid_b = 1'b0;

        // Async reset with the skid full, between clock edges
        out_ready_a  = 1'b0;
        in_valid_a   = 1'b1;
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h77};
        step();
        mux_inputs_a = {8'hD3, 8'hC2, 8'hB1, 8'h78};
        step();
        chk("ar_full_rdy",  {31'd0, in_ready_a}, 32'd0);
        chk("ar_full_data", {24'd0, mux_out_a},  32'h77);
        in_valid_a = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("ar_in_ready",  {31'd0, in_ready_a},  32'd1);
        chk("ar_mux_out",   {24'd0, mux_out_a},   32'h00);
        chk("ar_sel_err_b", {31'd0, sel_err_b},   32'd0);
        #1;
        rst         = 1'b1;
        out_ready_a = 1'b1;
        step();
        chk("ar_post_valid", {31'd0, out_valid_a}, 32'd0);
        chk("ar_post_rdy",   {31'd0, in_ready_a},  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nbit_mx1_skid_mux.md
Name: nbit_mx1_skid_mux

Overview:
- Parametrised successor to the team's N-bit 2:1 mux.
- Selects one of M N-bit sources and registers the result in a valid/ready pipeline stage with a one-entry skid buffer.
- in_ready is driven straight from a flop, so it does not ripple combinationally back through the stage.
- Used for operand/forwarding selection between stages of the pipelined RV32 core; supports flush for branch/hazard squash.

Parameters:
- N, 32, data width in bits.
- M, 4, number of sources (2..16; need not be a power of two).
- FLUSH_VAL, 0, N-bit value loaded into data registers on reset or flush.
- SEL_W, derived as clog2(M) (minimum 1), select width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- mux_inputs  input  M*N  flattened sources; source k occupies bits [k*N+N-1 : k*N].
- selection  input  SEL_W  source index, sampled together with in_valid.
- in_valid  input  1  upstream offers selection/mux_inputs this cycle.
- in_ready  output  1  stage can accept; registered.
- flush  input  1  synchronous squash of all held entries.
- mux_out  output  N  selected, registered data.
- out_valid  output  1  mux_out holds a valid entry.
- out_ready  input  1  downstream accepts mux_out this cycle.
- sel_err  output  1  sticky flag: an accepted transfer had selection >= M.

Behaviour:
- Reset (rst=0, async):
  - out_valid=0, in_ready=1, sel_err=0.
  - mux_out=FLUSH_VAL; skid register =FLUSH_VAL, skid_valid=0.
- Accept: in_valid & in_ready at a rising edge. Selected word = mux_inputs slice [selection].
- Out-of-range select (selection >= M): selected word = FLUSH_VAL; sel_err set on acceptance. It clears only on reset.
- Output register update when out_valid=0 or out_ready=1:
  - Load from skid if skid_valid=1, else from an accepted input.
  - out_valid is set if either source supplied data, else cleared.
- Skid capture: an accept while out_valid=1 and out_ready=0 is written to the skid register; skid_valid=1 and in_ready=0 next cycle.
- in_ready = ~skid_valid (registered). When the skid drains to the output, in_ready returns to 1 the following cycle.
- Latency:
  - 1 cycle input-to-output when unstalled.
  - Sustained throughput of 1 transfer per cycle with out_ready held high.
- Ordering: strict FIFO. The skid entry always leaves before any newer accept. Depth is 2 total (output register + skid).
- Flush:
  - Has priority over accept and drain in the same cycle.
  - Sets out_valid=0, skid_valid=0, mux_out=FLUSH_VAL; in_ready=1 next cycle.
  - Input offered in the flush cycle is dropped; sel_err is not updated by it.
- Simultaneous drain and accept with the skid empty: output loads the new word and out_valid stays 1, with no bubble.
- Simultaneous drain with the skid full: skid moves to output; in_ready is 0 that cycle, so no accept occurs.
- mux_out holds its value while out_valid=1 and out_ready=0; it must not change until the handshake completes.
- in_valid with in_ready=0: ignored; upstream must hold its data.
- Reset asserted mid-transfer: all state returns to reset values immediately, regardless of the clock.

Decomposition:
- defines.v gains the following, shared with the forwarding unit:
  - FWD_SRC_REG=0, FWD_SRC_EXMEM=1, FWD_SRC_MEMWB=2, FWD_SRC_IMM=3.
  - Default FLUSH_VAL constant (NOP-safe zero).
- One combinational sub-module, nbit_mx1_mux (N, M, FLUSH_VAL):
  - Pure M:1 selection with out-of-range output of FLUSH_VAL.
  - Generalises the existing 2:1 mux.
- The skid/handshake logic stays in the top module.

Test Plan:
- Reset/idle: rst=0 then 1, no in_valid -> out_valid=0, in_ready=1, mux_out=0, sel_err=0.
- Streaming: M=4 sources 0xA0,0xB1,0xC2,0xD3; selection 0,1,2,3 on consecutive cycles with out_ready=1 -> mux_out 0xA0,0xB1,0xC2,0xD3 one cycle later, out_valid continuously 1.
- Backpressure: out_ready=0 while two words (0x11, 0x22) are accepted -> in_ready falls to 0 after the second accept and mux_out holds 0x11. Raising out_ready then delivers 0x11 then 0x22, and in_ready returns to 1.
- Flush priority: output and skid both full, flush=1 with in_valid=1 (word 0x33) -> next cycle out_valid=0, in_ready=1, mux_out=0; 0x33 is never delivered.
- Out of range: M=3, selection=3, in_valid=1 -> mux_out=FLUSH_VAL with out_valid=1 and sel_err=1. sel_err stays 1 after later valid transfers until rst=0.
- Async reset mid-stream: assert rst low between clock edges with the skid full -> outputs at reset values before the next edge.
